awe_weight_table_ctrl: RTL and testbench



---
 rtl/awe_weight_table_ctrl_if.sv | 65 ++++++
 rtl/awe_weight_table_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_awe_weight_table_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/awe_weight_table_ctrl_if.sv
// -----------------------------------------------------------------------------
// awe_weight_table_ctrl_if
//   Bundles the signals of the AWE weight table controller. These are the load
//   configuration, the weight stream, the read requesters and both table RAM
//   ports.
//   slave  : the controller side (awe_weight_table_ctrl).
//   master : the environment side (loader, compute lanes, table RAM).
//   Optional macro AWE_WT_CHKSUM_EN adds load_chksum (controller output).
// -----------------------------------------------------------------------------
interface awe_weight_table_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int W_DEPTH = 8,
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2
) ();
    // load configuration
    logic                       cfg_start;
    logic [W_DEPTH-1:0]         cfg_base;
    logic [W_DEPTH:0]           cfg_len;
    logic                       load_busy;
    logic                       load_done;
    // weight stream
    logic                       wt_valid;
    logic [WIDTH-1:0]           wt_data;
    logic                       wt_ready;
    // read requesters
    logic [N_REQ-1:0]           rd_req;
    logic [N_REQ*W_DEPTH-1:0]   rd_addr;
    logic [N_REQ-1:0]           rd_gnt;
    logic                       rd_valid;
    logic [WIDTH-1:0]           rd_data;
    logic [ID_W-1:0]            rd_id;
    // table RAM ports
    logic [W_DEPTH-1:0]         ram_addra;
    logic [WIDTH-1:0]           ram_dina;
    logic                       ram_wea;
    logic [W_DEPTH-1:0]         ram_addrb;
    logic                       ram_web;
    logic [WIDTH-1:0]           ram_doutb;
`ifdef AWE_WT_CHKSUM_EN
    logic [WIDTH-1:0]           load_chksum;
`endif

    modport slave (
        input  cfg_start, cfg_base, cfg_len, wt_valid, wt_data,
               rd_req, rd_addr, ram_doutb,
        output
`ifdef AWE_WT_CHKSUM_EN
               load_chksum,
`endif
               load_busy, load_done, wt_ready, rd_gnt, rd_valid, rd_data,
               rd_id, ram_addra, ram_dina, ram_wea, ram_addrb, ram_web
    );

    modport master (
        output cfg_start, cfg_base, cfg_len, wt_valid, wt_data,
               rd_req, rd_addr, ram_doutb,
        input
`ifdef AWE_WT_CHKSUM_EN
               load_chksum,
`endif
               load_busy, load_done, wt_ready, rd_gnt, rd_valid, rd_data,
               rd_id, ram_addra, ram_dina, ram_wea, ram_addrb, ram_web
    );
endinterface

// File: rtl/awe_weight_table_ctrl.sv
// -----------------------------------------------------------------------------
// awe_weight_table_ctrl
//   Controller for the AWE dual-port weight table. It writes bulk weight loads
//   from a valid/ready stream into table port A. It also arbitrates table
//   port B between N_REQ read requesters, round-robin, and returns read data
//   tagged with the requester ID.
//
// Ports
//   clk_sys : single clock for all logic and both table ports
//   rst_b   : asynchronous active-low reset
//   bus     : awe_weight_table_ctrl_if.slave. It carries the cfg_* load
//             control, load_busy/load_done, the wt_* stream, the rd_*
//             requester bus and the ram_* table port signals.
//
// Optional macro AWE_WT_CHKSUM_EN
//   Adds bus.load_chksum, the mod-2**WIDTH sum of the words accepted in the
//   last load. It clears on cfg_start and holds from load_done until the next
//   cfg_start.
//
// State table
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for cfg_start; read arbitration active
//   ST_LOAD | accepting weight beats into port A; reads blocked
//   ST_DONE | one-cycle load_done pulse; reads blocked
// -----------------------------------------------------------------------------
module awe_weight_table_ctrl #(
    parameter int WIDTH   = 32,
    parameter int N_DEPTH = 256,
    parameter int W_DEPTH = 8,
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk_sys,
    input  logic                    rst_b,
    awe_weight_table_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_DEPTH-1:0] base_q, base_d;
    logic [W_DEPTH:0]   len_q, len_d;
    logic [W_DEPTH:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ID_W-1:0]    rd_id_q, rd_id_d;

    logic               beat;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_idx;

    // ---------------------------------------------------------------
    // Load sequencer
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        beat    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    base_d  = bus.cfg_base;
                    len_d   = bus.cfg_len;
                    cnt_d   = '0;
                    state_d = (bus.cfg_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                beat = bus.wt_valid;
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.wt_ready  = (state_q == ST_LOAD);
    assign bus.load_busy = (state_q == ST_LOAD);
    assign bus.load_done = (state_q == ST_DONE);
    assign bus.ram_wea   = beat;
    assign bus.ram_dina  = beat ? bus.wt_data : '0;
    // Base plus count taken modulo the depth so a load wraps from the top of the table to 0.
    assign bus.ram_addra = (state_q == ST_LOAD)
                         ? W_DEPTH'(({1'b0, base_q} + cnt_q) % N_DEPTH)
                         : '0;

    // ---------------------------------------------------------------
    // Read arbiter: round-robin search starting after the last grant.
    // Only active in IDLE so readers never observe a partial load.
    // ---------------------------------------------------------------
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state_q == ST_IDLE) begin
            for (int i = 1; i <= N_REQ; i++) begin
                idx = (int'(ptr_q) + i) % N_REQ;
                if (!gnt_any && bus.rd_req[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = ID_W'(idx);
                end
            end
        end
    end

    assign bus.rd_gnt    = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    assign bus.ram_addrb = gnt_any ? bus.rd_addr[gnt_idx*W_DEPTH +: W_DEPTH] : '0;
    assign bus.ram_web   = 1'b0;

    always_comb begin
        ptr_d      = gnt_any ? gnt_idx : ptr_q;
        rd_valid_d = gnt_any;
        rd_id_d    = gnt_any ? gnt_idx : rd_id_q;
    end

    // The RAM returns data one cycle after the address, which lines up with rd_valid_q.
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_id    = rd_id_q;
    assign bus.rd_data  = rd_valid_q ? bus.ram_doutb : '0;

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= ID_W'(N_REQ - 1);
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

`ifdef AWE_WT_CHKSUM_EN
    logic [WIDTH-1:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if ((state_q == ST_IDLE) && bus.cfg_start) begin
            chksum_d = '0;
        end else if (beat) begin
            chksum_d = chksum_q + bus.wt_data;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign bus.load_chksum = chksum_q;
`endif

endmodule

// File: tb/tb_awe_weight_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_awe_weight_table_ctrl
//   Directed bench for awe_weight_table_ctrl with a behavioural table RAM.
//   Expected read results go into a queue when the grant is checked. They are
//   popped and compared when rd_valid is due one cycle later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_awe_weight_table_ctrl;

    localparam int WIDTH   = 32;
    localparam int N_DEPTH = 256;
    localparam int W_DEPTH = 8;
    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } rd_exp_t;

    logic clk_sys = 1'b0;
    logic rst_b   = 1'b0;

    awe_weight_table_ctrl_if #(
        .WIDTH(WIDTH), .W_DEPTH(W_DEPTH), .N_REQ(N_REQ), .ID_W(ID_W)
    ) bus ();

    awe_weight_table_ctrl #(
        .WIDTH(WIDTH), .N_DEPTH(N_DEPTH), .W_DEPTH(W_DEPTH),
        .N_REQ(N_REQ), .ID_W(ID_W)
    ) dut (
        .clk_sys (clk_sys),
        .rst_b   (rst_b),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // behavioural dual-port table, 1-cycle read latency on port B
    logic [WIDTH-1:0] mem [N_DEPTH];
    always @(posedge clk_sys) begin
        if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
        bus.ram_doutb <= mem[bus.ram_addrb];
    end

    int               vectors     = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] ref_table [N_DEPTH];
    logic [W_DEPTH-1:0] req_addr [N_REQ];
    rd_exp_t          exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_addrs();
        bus.rd_addr = {req_addr[3], req_addr[2], req_addr[1], req_addr[0]};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".load_busy"}, bus.load_busy, 0);
        chk({tag, ".load_done"}, bus.load_done, 0);
        chk({tag, ".wt_ready"},  bus.wt_ready,  0);
        chk({tag, ".rd_gnt"},    bus.rd_gnt,    0);
        chk({tag, ".rd_valid"},  bus.rd_valid,  0);
        chk({tag, ".rd_id"},     bus.rd_id,     0);
        chk({tag, ".ram_wea"},   bus.ram_wea,   0);
        chk({tag, ".ram_addra"}, bus.ram_addra, 0);
        chk({tag, ".ram_dina"},  bus.ram_dina,  0);
        chk({tag, ".ram_addrb"}, bus.ram_addrb, 0);
        chk({tag, ".ram_web"},   bus.ram_web,   0);
`ifdef AWE_WT_CHKSUM_EN
        chk({tag, ".load_chksum"}, bus.load_chksum, 0);
`endif
    endtask

    task automatic check_read(input string tag);
        rd_exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ".rd_valid"}, bus.rd_valid, 1);
            chk({tag, ".rd_id"},    bus.rd_id,    e.id);
            chk({tag, ".rd_data"},  bus.rd_data,  e.data);
        end else begin
            chk({tag, ".rd_valid_idle"}, bus.rd_valid, 0);
        end
    endtask

    task automatic grant_expect(input string tag, input int idx);
        rd_exp_t e;
        chk({tag, ".rd_gnt"},    bus.rd_gnt,    64'(1) << idx);
        chk({tag, ".ram_addrb"}, bus.ram_addrb, req_addr[idx]);
        e.id   = ID_W'(idx);
        e.data = ref_table[req_addr[idx]];
        exp_q.push_back(e);
    endtask

    // One complete load. If toggle is set, wt_valid alternates 1,0,1,0...
    // If req_in_load is nonzero, those requests are raised after cfg_start and
    // must not be granted until the sequencer is back in IDLE.
    task automatic run_load(input string tag, input logic [W_DEPTH-1:0] base,
                            input int len, input logic [WIDTH-1:0] d0,
                            input logic [WIDTH-1:0] step, input bit toggle,
                            input logic [N_REQ-1:0] req_in_load);
        logic [WIDTH-1:0]   d;
        logic [WIDTH-1:0]   sum;
        logic [W_DEPTH-1:0] a;
        int                 k;
        int                 ph;
        d   = d0;
        sum = '0;
        k   = 0;
        ph  = 0;
        tick();
        bus.cfg_start = 1'b1;
        bus.cfg_base  = base;
        bus.cfg_len   = (W_DEPTH+1)'(len);
        settle();
        chk({tag, ".idle_busy"}, bus.load_busy, 0);
        tick();
        bus.cfg_start = 1'b0;
        bus.rd_req    = req_in_load;
        while (k < len) begin
            if (toggle && ph[0]) begin
                bus.wt_valid = 1'b0;
                settle();
                chk({tag, ".stall_busy"}, bus.load_busy, 1);
                chk({tag, ".stall_wea"},  bus.ram_wea,   0);
            end else begin
                bus.wt_valid = 1'b1;
                bus.wt_data  = d;
                a = W_DEPTH'((int'(base) + k) % N_DEPTH);
                settle();
                chk({tag, ".wt_ready"},  bus.wt_ready,  1);
                chk({tag, ".load_busy"}, bus.load_busy, 1);
                chk({tag, ".ram_wea"},   bus.ram_wea,   1);
                chk({tag, ".ram_addra"}, bus.ram_addra, a);
                chk({tag, ".ram_dina"},  bus.ram_dina,  d);
                ref_table[a] = d;
                sum = sum + d;
                d   = d + step;
                k++;
            end
            if (req_in_load != '0) chk({tag, ".blocked_gnt"}, bus.rd_gnt, 0);
            ph++;
            tick();
        end
        bus.wt_valid = 1'b0;
        settle();
        chk({tag, ".load_done"},   bus.load_done, 1);
        chk({tag, ".done_busy"},   bus.load_busy, 0);
        chk({tag, ".done_wea"},    bus.ram_wea,   0);
        if (req_in_load != '0) chk({tag, ".done_gnt"}, bus.rd_gnt, 0);
`ifdef AWE_WT_CHKSUM_EN
        chk({tag, ".load_chksum"}, bus.load_chksum, sum);
`endif
        tick();
        settle();
        chk({tag, ".done_clear"},  bus.load_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_DEPTH; i++) ref_table[i] = '0;
        for (int i = 0; i < N_REQ; i++) req_addr[i] = W_DEPTH'(i);
        bus.cfg_start = 1'b0;
        bus.cfg_base  = '0;
        bus.cfg_len   = '0;
        bus.wt_valid  = 1'b0;
        bus.wt_data   = '0;
        bus.rd_req    = '0;
        drive_addrs();

        // reset
        repeat (2) @(posedge clk_sys);
        #3;
        chk_reset_outputs("reset");
        rst_b = 1'b1;

        // basic load, no stalls: 0x11..0x44 to addresses 0..3, checksum 0xAA
        run_load("load4", 8'h00, 4, 32'h11, 32'h11, 1'b0, '0);

        // round robin, all requesters held, addr = index
        tick();
        bus.rd_req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            settle();
            check_read("rr");
            grant_expect("rr", n % N_REQ);
            tick();
        end
        bus.rd_req = '0;
        settle();
        check_read("rr_tail");
        chk("rr_nogrant", bus.rd_gnt, 0);
        tick();
        settle();
        check_read("rr_quiet");

        // wrapping load with wt_valid toggling
        run_load("wrap", 8'hFE, 4, 32'hA0, 32'h1, 1'b1, '0);

        // zero-length load
        run_load("len0", 8'h33, 0, 32'h0, 32'h0, 1'b0, '0);

        // request raised during LOAD is held off until IDLE
        req_addr[2] = 8'h10;
        drive_addrs();
        run_load("block", 8'h10, 2, 32'h700, 32'h1, 1'b0, 4'b0100);
        grant_expect("block_idle", 2);
        tick();
        bus.rd_req = '0;
        settle();
        check_read("block_rd");

        // cfg_start and a read request in the same IDLE cycle
        tick();
        bus.cfg_start = 1'b1;
        bus.cfg_base  = 8'h40;
        bus.cfg_len   = 9'd1;
        bus.rd_req    = 4'b0001;
        settle();
        grant_expect("simul", 0);
        tick();
        bus.cfg_start = 1'b0;
        bus.rd_req    = '0;
        bus.wt_valid  = 1'b1;
        bus.wt_data   = 32'h5A;
        settle();
        check_read("simul_rd");
        chk("simul.load_busy", bus.load_busy, 1);
        chk("simul.ram_wea",   bus.ram_wea,   1);
        chk("simul.ram_addra", bus.ram_addra, 8'h40);
        ref_table[8'h40] = 32'h5A;
        tick();
        bus.wt_valid = 1'b0;
        settle();
        chk("simul.load_done", bus.load_done, 1);
        tick();

        // reset in the middle of an 8-word load after 2 beats
        bus.cfg_start = 1'b1;
        bus.cfg_base  = 8'h20;
        bus.cfg_len   = 9'd8;
        tick();
        bus.cfg_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wt_valid = 1'b1;
            bus.wt_data  = 32'hB0 + k;
            ref_table[8'h20 + k] = 32'hB0 + k;
            tick();
        end
        bus.wt_valid = 1'b1;
        bus.wt_data  = 32'hB2;
        settle();
        chk("midload.ram_wea", bus.ram_wea, 1);
        rst_b = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        bus.wt_valid = 1'b0;
        tick();
        rst_b = 1'b1;

        // reload after reset, then read back word 0x21 via requester 1
        run_load("reload", 8'h20, 2, 32'hC0, 32'h1, 1'b0, '0);
        req_addr[1] = 8'h21;
        drive_addrs();
        bus.rd_req = 4'b0010;
        settle();
        grant_expect("reload_rd", 1);
        tick();
        bus.rd_req = '0;
        settle();
        check_read("reload_rd");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
